rf_write_scheduler: RTL and testbench

//  - Shares the single register-file write port between two writeback requesters: req0 = ALU, req1 = load/memory.
//  - Round-robin arbitration over a valid/ready handshake.
//  - Also sequences a bulk clear: writes CLEAR_VALUE to registers 1..NUM_REGS-1, one per cycle.
//  - Sits between the writeback stage and the register file's reg_write/write_register/write_data inputs.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rf_write_scheduler_if.sv | 37 +++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/rf_write_scheduler.sv | 96 +++++++++
 tb/tb_rf_write_scheduler.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and state encoding for the register-file write scheduler
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [DATA_W-1:0] CLEAR_VALUE = 32'h0000_0000;

    // Last register index touched by the bulk clear; register 0 is never written
    localparam logic [ADDR_W-1:0] CLEAR_LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// rtl/rf_write_scheduler_if.sv - writeback request handshakes and register-file write port bundle
interface rf_write_scheduler_if;
    import regfile_pkg::*;

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_write_register;
    logic [DATA_W-1:0] rf_write_data;

    // Writeback side: drives requests, observes readies and the register-file port
    modport master (
        output req0_valid, req0_reg, req0_data,
        input  req0_ready,
        output req1_valid, req1_reg, req1_data,
        input  req1_ready,
        input  rf_reg_write, rf_write_register, rf_write_data
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_reg, req0_data,
        output req0_ready,
        input  req1_valid, req1_reg, req1_data,
        output req1_ready,
        output rf_reg_write, rf_write_register, rf_write_data
    );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, purely combinational
module rr_arbiter2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_enable,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // A lone requester always wins; on a conflict the one not granted last time wins
    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            if (i_valid0 && (!i_valid1 || i_last_grant)) begin
                o_grant = 2'b01;
            end else if (i_valid1) begin
                o_grant = 2'b10;
            end
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - shares the register-file write port between ALU and load writeback, plus bulk clear
module rf_write_scheduler
    import regfile_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear_start,
    output logic                 o_clear_busy,
    output logic                 o_last_grant,
    rf_write_scheduler_if.slave  bus
);

    sched_state_t      r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_clear_busy;
    logic              r_last_grant;
    logic              r_rf_reg_write;
    logic [ADDR_W-1:0] r_rf_write_register;
    logic [DATA_W-1:0] r_rf_write_data;

    logic              w_arb_enable;
    logic [1:0]        w_grant;

    // A clear request takes the cycle it arrives in, so no writeback is accepted then
    assign w_arb_enable = (r_state == ST_ARB) && !i_clear_start;

    rr_arbiter2 u_arb (
        .i_valid0     (bus.req0_valid),
        .i_valid1     (bus.req1_valid),
        .i_enable     (w_arb_enable),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign bus.req0_ready        = w_grant[0];
    assign bus.req1_ready        = w_grant[1];
    assign bus.rf_reg_write      = r_rf_reg_write;
    assign bus.rf_write_register = r_rf_write_register;
    assign bus.rf_write_data     = r_rf_write_data;
    assign o_clear_busy          = r_clear_busy;
    assign o_last_grant          = r_last_grant;

    // FSM: arbitration or clear walk, with registered register-file outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state             <= ST_ARB;
            r_idx               <= '0;
            r_clear_busy        <= 1'b0;
            r_last_grant        <= 1'b1;
            r_rf_reg_write      <= 1'b0;
            r_rf_write_register <= '0;
            r_rf_write_data     <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    r_rf_reg_write <= 1'b0;
                    if (i_clear_start) begin
                        r_state      <= ST_CLEAR;
                        r_idx        <= ADDR_W'(1);
                        r_clear_busy <= 1'b1;
                    end else if (w_grant[0]) begin
                        r_last_grant <= 1'b0;
                        // Writes to register 0 are accepted but never reach the file
                        if (bus.req0_reg != '0) begin
                            r_rf_reg_write      <= 1'b1;
                            r_rf_write_register <= bus.req0_reg;
                            r_rf_write_data     <= bus.req0_data;
                        end
                    end else if (w_grant[1]) begin
                        r_last_grant <= 1'b1;
                        if (bus.req1_reg != '0) begin
                            r_rf_reg_write      <= 1'b1;
                            r_rf_write_register <= bus.req1_reg;
                            r_rf_write_data     <= bus.req1_data;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_rf_reg_write      <= 1'b1;
                    r_rf_write_register <= r_idx;
                    r_rf_write_data     <= CLEAR_VALUE;
                    if (r_idx == CLEAR_LAST_IDX) begin
                        r_state      <= ST_ARB;
                        r_clear_busy <= 1'b0;
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb/tb_rf_write_scheduler.sv - self-checking bench for rf_write_scheduler
module tb_rf_write_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_start = 1'b0;
    logic clear_busy;
    logic last_grant;

    rf_write_scheduler_if bus ();

    rf_write_scheduler dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_clear_start (clear_start),
        .o_clear_busy  (clear_busy),
        .o_last_grant  (last_grant),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        er0;
        logic        er1;
    } vec_t;

    typedef struct {
        logic        we;
        logic        chk;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    localparam int NV = 11;
    vec_t vecs [NV];
    exp_t sb [$];
    exp_t e;

    int n_tests = 0;
    int n_fail  = 0;
    logic        m_lg;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int busy_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd3,  32'h0000_0003, 1'b1, 5'd9,  32'h0000_0009, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 5'd3,  32'h0000_0003, 1'b1, 5'd9,  32'h0000_0009, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 5'd3,  32'h0000_0003, 1'b1, 5'd9,  32'h0000_0009, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 5'd3,  32'h0000_0003, 1'b1, 5'd9,  32'h0000_0009, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 5'd8,  32'hA5A5_A5A5, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd17, 32'h1234_5678, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 5'd4,  32'hDEAD_BEEF, 1'b1, 5'd6,  32'hCAFE_F00D, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 5'd0,  32'h1111_1111, 1'b1, 5'd2,  32'h2222_2222, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 5'd0,  32'h3333_3333, 1'b1, 5'd7,  32'h4444_4444, 1'b1, 1'b0};

        bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset rf_reg_write", 32'(bus.rf_reg_write), 32'd0);
        chk("reset rf_write_register", 32'(bus.rf_write_register), 32'd0);
        chk("reset rf_write_data", bus.rf_write_data, 32'd0);
        chk("reset clear_busy", 32'(clear_busy), 32'd0);
        chk("reset last_grant", 32'(last_grant), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven arbitration vectors with scoreboard of rf writes
        m_lg = 1'b1; m_addr = '0; m_data = '0;
        for (int i = 0; i < NV; i++) begin
            bus.req0_valid = vecs[i].v0; bus.req0_reg = vecs[i].a0; bus.req0_data = vecs[i].d0;
            bus.req1_valid = vecs[i].v1; bus.req1_reg = vecs[i].a1; bus.req1_data = vecs[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].er0));
            chk($sformatf("v%0d req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].er1));
            if (vecs[i].er0) begin
                m_lg = 1'b0;
                if (vecs[i].a0 != 0) begin
                    m_addr = vecs[i].a0; m_data = vecs[i].d0;
                    sb.push_back('{1'b1, 1'b1, m_addr, m_data});
                end else sb.push_back('{1'b0, 1'b0, m_addr, m_data});
            end else if (vecs[i].er1) begin
                m_lg = 1'b1;
                if (vecs[i].a1 != 0) begin
                    m_addr = vecs[i].a1; m_data = vecs[i].d1;
                    sb.push_back('{1'b1, 1'b1, m_addr, m_data});
                end else sb.push_back('{1'b0, 1'b0, m_addr, m_data});
            end else begin
                sb.push_back('{1'b0, 1'b1, m_addr, m_data});
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d rf_reg_write", i), 32'(bus.rf_reg_write), 32'(e.we));
            if (e.chk) begin
                chk($sformatf("v%0d rf_write_register", i), 32'(bus.rf_write_register), 32'(e.a));
                chk($sformatf("v%0d rf_write_data", i), bus.rf_write_data, e.d);
            end
            chk($sformatf("v%0d last_grant", i), 32'(last_grant), 32'(m_lg));
        end

        // Clear sequence with req0 pending; a second clear_start mid-walk is ignored
        bus.req0_valid = 1'b1; bus.req0_reg = 5'd5; bus.req0_data = 32'h0000_0055;
        bus.req1_valid = 1'b0;
        clear_start = 1'b1;
        @(negedge clk);
        chk("clear_start req0_ready", 32'(bus.req0_ready), 32'd0);
        chk("clear_start req1_ready", 32'(bus.req1_ready), 32'd0);
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        busy_cnt = clear_busy ? 1 : 0;
        chk("clear start rf_reg_write", 32'(bus.rf_reg_write), 32'd0);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            chk($sformatf("clear k%0d req0_ready", k), 32'(bus.req0_ready), 32'd0);
            if (k == 10) clear_start = 1'b1;
            @(posedge clk);
            #1;
            clear_start = 1'b0;
            if (clear_busy) busy_cnt++;
            chk($sformatf("clear k%0d rf_reg_write", k), 32'(bus.rf_reg_write), 32'd1);
            chk($sformatf("clear k%0d rf_write_register", k), 32'(bus.rf_write_register), 32'(k));
            chk($sformatf("clear k%0d rf_write_data", k), bus.rf_write_data, 32'd0);
        end
        chk("clear busy cycles", 32'(busy_cnt), 32'd31);
        chk("clear busy after", 32'(clear_busy), 32'd0);
        @(negedge clk);
        chk("post-clear req0_ready", 32'(bus.req0_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        chk("post-clear rf_reg_write", 32'(bus.rf_reg_write), 32'd1);
        chk("post-clear rf_write_register", 32'(bus.rf_write_register), 32'd5);
        chk("post-clear rf_write_data", bus.rf_write_data, 32'h0000_0055);
        chk("post-clear last_grant", 32'(last_grant), 32'd0);

        // Reset asserted mid-clear at idx 12
        bus.req0_valid = 1'b1; bus.req0_reg = 5'd3; bus.req0_data = 32'h0000_0003;
        bus.req1_valid = 1'b1; bus.req1_reg = 5'd9; bus.req1_data = 32'h0000_0009;
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("midclear rf_write_register", 32'(bus.rf_write_register), 32'd11);
        chk("midclear clear_busy", 32'(clear_busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset rf_reg_write", 32'(bus.rf_reg_write), 32'd0);
        chk("async reset clear_busy", 32'(clear_busy), 32'd0);
        chk("async reset last_grant", 32'(last_grant), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset req0_ready", 32'(bus.req0_ready), 32'd1);
        chk("post-reset req1_ready", 32'(bus.req1_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("post-reset rf_reg_write", 32'(bus.rf_reg_write), 32'd1);
        chk("post-reset rf_write_register", 32'(bus.rf_write_register), 32'd3);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
